// File: rtl/vga_sync_controller_pkg.sv
// Shared constants for the VGA sync controller.
// Colour channel slices and coordinate width.
package vga_sync_controller_pkg;

   localparam int COORD_W = 10;

   localparam int R_HI = 23;
   localparam int R_LO = 16;
   localparam int G_HI = 15;
   localparam int G_LO = 8;
   localparam int B_HI = 7;
   localparam int B_LO = 0;

endpackage

// File: rtl/vga_sync_controller_axis.sv
// One raster axis: wrapping counter with active/sync decode.
// Ordering along the axis is active, front porch, sync, back porch.
module vga_axis_counter
   import vga_sync_controller_pkg::*;
#(
   parameter int ACTIVE = 640,
   parameter int FRONT  = 16,
   parameter int SYNC   = 96,
   parameter int BACK   = 48
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   output logic [COORD_W-1:0] count,
   output logic               in_active,
   output logic               sync_n,
   output logic               at_last
);

   localparam int TOTAL   = ACTIVE + FRONT + SYNC + BACK;
   localparam int SYNC_LO = ACTIVE + FRONT;
   localparam int SYNC_HI = SYNC_LO + SYNC;

   logic [31:0] cnt32;

   assign cnt32     = 32'(count);
   assign at_last   = (cnt32 == 32'(TOTAL - 1));
   assign in_active = (cnt32 < 32'(ACTIVE));
   assign sync_n    = !((cnt32 >= 32'(SYNC_LO)) &&
                        (cnt32 <  32'(SYNC_HI)));

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (enable)
         count <= at_last ? '0 : count + 1'b1;
   end

endmodule

// File: rtl/vga_sync_controller.sv
// VGA raster timing generator with colour gating.
// Pixel rate is clk divided by PIX_DIV.
module vga_sync_controller
   import vga_sync_controller_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int PIX_DIV  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [23:0]        color_in,
   output logic               screenend,
   output logic               active,
   output logic [COORD_W-1:0] active_x,
   output logic [COORD_W-1:0] active_y,
   output logic               hsync,
   output logic               vsync,
   output logic [7:0]         red,
   output logic [7:0]         green,
   output logic [7:0]         blue
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

   logic [DIV_W-1:0]   div;
   logic               pix_tick;
   logic [COORD_W-1:0] h_cnt;
   logic [COORD_W-1:0] v_cnt;
   logic               h_act;
   logic               v_act;
   logic               h_last;
   logic               v_last;

   assign pix_tick = (32'(div) == 32'(PIX_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)
         div <= '0;
      else if (pix_tick)
         div <= '0;
      else
         div <= div + 1'b1;
   end

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FRONT  (H_FRONT),
      .SYNC   (H_SYNC),
      .BACK   (H_BACK)
   ) u_h (
      .clk       (clk),
      .rst       (rst),
      .enable    (pix_tick),
      .count     (h_cnt),
      .in_active (h_act),
      .sync_n    (hsync),
      .at_last   (h_last)
   );

   // Rows advance only on the last pixel of a line.
   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FRONT  (V_FRONT),
      .SYNC   (V_SYNC),
      .BACK   (V_BACK)
   ) u_v (
      .clk       (clk),
      .rst       (rst),
      .enable    (pix_tick && h_last),
      .count     (v_cnt),
      .in_active (v_act),
      .sync_n    (vsync),
      .at_last   (v_last)
   );

   assign active    = h_act && v_act;
   assign screenend = pix_tick && h_last && v_last;
   assign active_x  = active ? h_cnt : '0;
   assign active_y  = active ? v_cnt : '0;
   assign red       = active ? color_in[R_HI:R_LO] : '0;
   assign green     = active ? color_in[G_HI:G_LO] : '0;
   assign blue      = active ? color_in[B_HI:B_LO] : '0;

endmodule

// File: tb/tb_vga_sync_controller.sv
// Directed bench for vga_sync_controller (32x22 raster, /4).
module tb_vga_sync_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] color_in = 24'hFFFFFF;
   logic        screenend;
   logic        active;
   logic [9:0]  active_x;
   logic [9:0]  active_y;
   logic        hsync;
   logic        vsync;
   logic [7:0]  red;
   logic [7:0]  green;
   logic [7:0]  blue;

   int checks   = 0;
   int failures = 0;

   vga_sync_controller #(
      .H_ACTIVE (20), .H_FRONT (3), .H_SYNC (4), .H_BACK (5),
      .V_ACTIVE (10), .V_FRONT (3), .V_SYNC (4), .V_BACK (5),
      .PIX_DIV  (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .color_in  (color_in),
      .screenend (screenend),
      .active    (active),
      .active_x  (active_x),
      .active_y  (active_y),
      .hsync     (hsync),
      .vsync     (vsync),
      .red       (red),
      .green     (green),
      .blue      (blue)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int hs_low;
   int vs_low;
   int act_blank;
   int act_total;
   int se_cnt;
   int se_k0;
   int se_k1;

   initial begin
      hs_low = 0; vs_low = 0; act_blank = 0;
      act_total = 0; se_cnt = 0; se_k0 = -1; se_k1 = -1;

      step(2);
      chk("rst_active", 32'(active), 1);
      chk("rst_xy", {active_x, active_y}, 0);
      chk("rst_sync", {hsync, vsync}, 2'b11);
      chk("rst_se", 32'(screenend), 0);
      chk("rst_rgb", {red, green, blue}, 24'hFFFFFF);
      rst = 1'b0;

      // k = clk cycles since frame start
      for (int k = 0; k < 5632; k++) begin
         if (k < 128 && !hsync) hs_low++;
         if (k < 2816 && !vsync) vs_low++;
         if (k >= 1280 && k < 2816 && active) act_blank++;
         if (k < 2816 && active) act_total++;
         if (screenend) begin
            se_cnt++;
            if (se_k0 < 0) se_k0 = k;
            else if (se_k1 < 0) se_k1 = k;
         end
         case (k)
            3:    chk("x_hold", active_x, 0);
            4:    chk("x_step", active_x, 1);
            79:   chk("x_last", {active, active_x}, {1'b1, 10'd19});
            80: begin
               chk("h_blank", {active, active_x}, 0);
               chk("h_blank_rgb", {red, green, blue}, 0);
            end
            91:   chk("hs_pre", 32'(hsync), 1);
            92:   chk("hs_start", 32'(hsync), 0);
            107:  chk("hs_end", 32'(hsync), 0);
            108:  chk("hs_post", 32'(hsync), 1);
            128:  chk("line1", {active, active_x, active_y},
                      {1'b1, 10'd0, 10'd1});
            1152: chk("y_last", {active, active_y}, {1'b1, 10'd9});
            1280: chk("v_blank", {active, active_y}, 0);
            1663: chk("vs_pre", 32'(vsync), 1);
            1664: chk("vs_start", {hsync, vsync}, 2'b10);
            2175: chk("vs_end", 32'(vsync), 0);
            2176: chk("vs_post", 32'(vsync), 1);
            2814: chk("se_early", 32'(screenend), 0);
            2815: chk("se_pulse", 32'(screenend), 1);
            2816: chk("se_after", {screenend, active, active_x, active_y},
                      {1'b0, 1'b1, 10'd0, 10'd0});
            default: ;
         endcase
         step(1);
      end
      chk("hs_low_clk", hs_low, 16);
      chk("vs_low_clk", vs_low, 512);
      chk("act_vblank", act_blank, 0);
      chk("act_total", act_total, 800);
      chk("se_count", se_cnt, 2);
      chk("se_period", se_k1 - se_k0, 2816);

      // frame 3 start, active pixel (0,0)
      color_in = 24'h123456;
      #1;
      chk("rgb_pass", {red, green, blue}, 24'h123456);
      step(80);
      chk("rgb_blank", {red, green, blue}, 0);

      // move to h=25, v=14 (offset 1892 in frame)
      step(1892 - 80);
      chk("mid_pre", {hsync, vsync}, 2'b00);
      rst = 1'b1;
      step(1);
      chk("mid_sync", {hsync, vsync}, 2'b11);
      chk("mid_xy", {active, active_x, active_y}, {1'b1, 20'd0});
      chk("mid_se", 32'(screenend), 0);
      rst = 1'b0;
      step(4);
      chk("mid_x1", active_x, 1);
      step(2810);
      chk("mid_se_early", 32'(screenend), 0);
      step(1);
      chk("mid_se_pulse", 32'(screenend), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_sync_controller.md
Name: vga_sync_controller

Overview:
- Generates VGA raster timing: horizontal/vertical sync, active-video flag, pixel coordinates and an end-of-frame strobe.
- Gates a 24-bit RGB colour input onto 8-bit red/green/blue outputs during the visible region.
- Runs on the system clock; a programmable divider derives the pixel rate.
- Sits between the pixel generator (which consumes active_x/active_y and returns color_in) and the VGA DAC/pins.

Parameters:
- H_ACTIVE, 640: visible pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync pulse width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync pulse width, in lines.
- V_BACK, 33: vertical back porch, in lines.
- PIX_DIV, 4: clk cycles per pixel. Must be ≥1.
- Constraint: H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters; both must be ≤1024.

Ports:
- clk, input, 1: system clock; all state is updated on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- color_in, input, 24: pixel colour; [23:16]=R, [15:8]=G, [7:0]=B.
- screenend, output, 1: end-of-frame strobe.
- active, output, 1: high while the current pixel is in the visible region.
- active_x, output, 10: current visible column.
- active_y, output, 10: current visible row.
- hsync, output, 1: horizontal sync, active-low.
- vsync, output, 1: vertical sync, active-low.
- red, output, 8: red channel.
- green, output, 8: green channel.
- blue, output, 8: blue channel.

Behaviour:
- Pixel divider:
  - div counter runs 0..PIX_DIV-1 and wraps.
  - pix_tick = (div == PIX_DIV-1). With PIX_DIV=1, pix_tick is high every cycle.
- Horizontal counter h_cnt (10 bit):
  - Increments on pix_tick.
  - Wraps H_TOTAL-1 → 0.
- Vertical counter v_cnt (10 bit):
  - Increments on pix_tick when h_cnt == H_TOTAL-1.
  - Wraps V_TOTAL-1 → 0.
- Line ordering: active, front porch, sync, back porch. Frame ordering is the same.
- hsync = 0 iff H_ACTIVE+H_FRONT ≤ h_cnt < H_ACTIVE+H_FRONT+H_SYNC; otherwise 1.
- vsync = 0 iff V_ACTIVE+V_FRONT ≤ v_cnt < V_ACTIVE+V_FRONT+V_SYNC; otherwise 1. vsync is line-based and does not depend on h_cnt.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- active_x = h_cnt and active_y = v_cnt while active; both are 0 while not active.
- {red, green, blue} = color_in while active; 0 otherwise.
- color_in is combinational pass-through, zero latency relative to active_x/active_y.
- screenend = pix_tick && h_cnt == H_TOTAL-1 && v_cnt == V_TOTAL-1.
  - Exactly one clk cycle wide.
  - Asserted once per frame, on the cycle before the counters return to (0,0).
- All timing outputs are decoded combinationally from the registered counters.
- Reset:
  - div, h_cnt and v_cnt are cleared to 0 on the next clk edge.
  - Resulting outputs: active=1, active_x=0, active_y=0, hsync=1, vsync=1, screenend=0, RGB=color_in.
  - A reset asserted mid-frame restarts the frame at (0,0) with no partial strobe.
- Each pixel lasts exactly PIX_DIV clk cycles.
- Frame period = H_TOTAL·V_TOTAL·PIX_DIV clk cycles.

Decomposition:
- Shared package: colour-slice constants (R/G/B bit ranges) and the 10-bit coordinate width.
- H_TOTAL and V_TOTAL are local constants derived from the parameters.
- One natural sub-module: vga_axis_counter, instantiated twice (horizontal and vertical).
  - Parameters: ACTIVE, FRONT, SYNC, BACK.
  - Inputs: enable (count), with wrap.
  - Outputs: count, in_active, sync_n, at_last.
  - The vertical instance is enabled by pix_tick && h.at_last.

Test Plan (bench configuration H=20/3/4/5, V=10/3/4/5, PIX_DIV=4, color_in=24'hFFFFFF, giving H_TOTAL=32, V_TOTAL=22):
- Reset check: rst high for 2 cycles, then release → active=1, active_x=0, active_y=0, hsync=1, vsync=1, RGB=FF/FF/FF. Each x value then holds for 4 clk cycles.
- Horizontal timing:
  - active_x goes 0..19 (80 clk), then active=0 and RGB=0.
  - hsync is low for h_cnt 23..26, i.e. exactly 16 clk per line.
  - Line period is 128 clk.
- Vertical timing:
  - active_y goes 0..9.
  - vsync is low for lines 13..16, i.e. 4·128 = 512 clk.
  - active is never 1 on lines 10..21.
- Frame strobe: screenend is a single-cycle pulse every 2816 clk; the next cycle has h_cnt=0, v_cnt=0 and active=1.
- Mid-frame reset: pulse rst at h_cnt=25, v_cnt=14 (both syncs low) → the next cycle shows hsync=1, vsync=1, active_x=0, active_y=0, and there is no screenend pulse.
- Colour gating: change color_in to 24'h123456 during active → red=12, green=34, blue=56 in the same cycle; during blanking all channels are 0.
